// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALUv vector ALU among NUM_REQ requesters, one operation in flight.
// Optional busy-cycle counter output enabled by defining ALU_ARB_BUSY_CNT_EN.
module alu_req_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALUS_NUM    = 4,
  parameter int INPUT_WIDTH = 8,
  parameter int ALU_LATENCY = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ*4-1:0]                  req_opcode,
  input  logic [NUM_REQ*ALUS_NUM*INPUT_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ALUS_NUM*INPUT_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  input  logic [NUM_REQ-1:0]                    rsp_ready,
  output logic [ALUS_NUM*2*INPUT_WIDTH-1:0]     rsp_result,
  output logic [ALUS_NUM-1:0]                   rsp_gt,
  output logic [ALUS_NUM-1:0]                   rsp_eq,
  output logic [ALUS_NUM-1:0]                   rsp_lt,
  output logic                                  alu_enable,
  output logic [3:0]                            alu_opcode,
  output logic [ALUS_NUM*INPUT_WIDTH-1:0]       alu_a,
  output logic [ALUS_NUM*INPUT_WIDTH-1:0]       alu_b,
  input  logic [ALUS_NUM*2*INPUT_WIDTH-1:0]     alu_result,
  input  logic [ALUS_NUM-1:0]                   alu_gt,
  input  logic [ALUS_NUM-1:0]                   alu_eq,
  input  logic [ALUS_NUM-1:0]                   alu_lt
`ifdef ALU_ARB_BUSY_CNT_EN
  ,
  output logic [31:0]                           busy_cycles
`endif
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);
  localparam int LW = ALUS_NUM * INPUT_WIDTH;
  localparam int RW = ALUS_NUM * 2 * INPUT_WIDTH;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_q, gnt_d;
  logic [CW-1:0]   lat_cnt_q, lat_cnt_d;
  logic [3:0]      alu_opcode_q;
  logic [LW-1:0]   alu_a_q, alu_b_q;
  logic [RW-1:0]   rsp_result_q;
  logic [ALUS_NUM-1:0] rsp_gt_q, rsp_eq_q, rsp_lt_q;

  logic            found;
  logic [PW-1:0]   pick;
  logic            load_alu;
  logic            cap_rsp;

  // First requesting index at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    lat_cnt_d = lat_cnt_q;
    load_alu  = 1'b0;
    cap_rsp   = 1'b0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready[pick] = 1'b1;
          gnt_d           = pick;
          load_alu        = 1'b1;
          lat_cnt_d       = CW'(ALU_LATENCY);
          state_d         = EXEC;
        end
      end
      EXEC: begin
        // One extra cycle beyond ALU_LATENCY lets ALUv register the new operands first.
        if (lat_cnt_q == '0) begin
          cap_rsp = 1'b1;
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[gnt_q]) begin
          rr_ptr_d = (int'(gnt_q) == NUM_REQ - 1) ? '0 : gnt_q + PW'(1);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      lat_cnt_q    <= '0;
      alu_opcode_q <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_result_q <= '0;
      rsp_gt_q     <= '0;
      rsp_eq_q     <= '0;
      rsp_lt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      lat_cnt_q <= lat_cnt_d;
      if (load_alu) begin
        alu_opcode_q <= req_opcode[int'(pick)*4 +: 4];
        alu_a_q      <= req_a[int'(pick)*LW +: LW];
        alu_b_q      <= req_b[int'(pick)*LW +: LW];
      end
      if (cap_rsp) begin
        rsp_result_q <= alu_result;
        rsp_gt_q     <= alu_gt;
        rsp_eq_q     <= alu_eq;
        rsp_lt_q     <= alu_lt;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == RESP) rsp_valid[gnt_q] = 1'b1;
  end

  assign alu_enable = (state_q == EXEC);
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign rsp_result = rsp_result_q;
  assign rsp_gt     = rsp_gt_q;
  assign rsp_eq     = rsp_eq_q;
  assign rsp_lt     = rsp_lt_q;

`ifdef ALU_ARB_BUSY_CNT_EN
  logic [31:0] busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else if (state_q != IDLE && busy_q != 32'hFFFF_FFFF) begin
      busy_q <= busy_q + 32'd1;
    end
  end

  assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a stub ALUv (per-lane A*B and compares) and a transaction-level model.
module tb_alu_req_arbiter;
  localparam int N  = 4;
  localparam int AL = 4;
  localparam int IW = 8;
  localparam int L  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0]         req_ready;
  logic [N*4-1:0]       req_opcode = '0;
  logic [N*AL*IW-1:0]   req_a = '0;
  logic [N*AL*IW-1:0]   req_b = '0;
  logic [N-1:0]         rsp_valid;
  logic [N-1:0]         rsp_ready = '0;
  logic [AL*2*IW-1:0]   rsp_result;
  logic [AL-1:0]        rsp_gt, rsp_eq, rsp_lt;
  logic                 alu_enable;
  logic [3:0]           alu_opcode;
  logic [AL*IW-1:0]     alu_a, alu_b;
  logic [AL*2*IW-1:0]   alu_result;
  logic [AL-1:0]        alu_gt, alu_eq, alu_lt;
`ifdef ALU_ARB_BUSY_CNT_EN
  logic [31:0]          busy_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  alu_req_arbiter #(.NUM_REQ(N), .ALUS_NUM(AL), .INPUT_WIDTH(IW), .ALU_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_gt(rsp_gt), .rsp_eq(rsp_eq), .rsp_lt(rsp_lt),
    .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_gt(alu_gt), .alu_eq(alu_eq), .alu_lt(alu_lt)
`ifdef ALU_ARB_BUSY_CNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALUv: L register stages of per-lane product and compare flags.
  logic [AL*2*IW-1:0] f_res;
  logic [AL-1:0]      f_gt, f_eq, f_lt;
  logic [AL*2*IW-1:0] s_res [L];
  logic [AL-1:0]      s_gt [L], s_eq [L], s_lt [L];

  always_comb begin
    f_res = '0; f_gt = '0; f_eq = '0; f_lt = '0;
    for (int i = 0; i < AL; i++) begin
      f_res[i*2*IW +: 2*IW] = alu_a[i*IW +: IW] * alu_b[i*IW +: IW];
      f_gt[i] = alu_a[i*IW +: IW] >  alu_b[i*IW +: IW];
      f_eq[i] = alu_a[i*IW +: IW] == alu_b[i*IW +: IW];
      f_lt[i] = alu_a[i*IW +: IW] <  alu_b[i*IW +: IW];
    end
  end

  always @(posedge clk) begin
    s_res[0] <= f_res; s_gt[0] <= f_gt; s_eq[0] <= f_eq; s_lt[0] <= f_lt;
    for (int s = 1; s < L; s++) begin
      s_res[s] <= s_res[s-1]; s_gt[s] <= s_gt[s-1]; s_eq[s] <= s_eq[s-1]; s_lt[s] <= s_lt[s-1];
    end
  end

  assign alu_result = s_res[L-1];
  assign alu_gt = s_gt[L-1];
  assign alu_eq = s_eq[L-1];
  assign alu_lt = s_lt[L-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: who owns the ALU, how many cycles since its grant, and the result it should see.
  bit           m_busy = 0;
  int           m_g = 0;
  int           m_t = 0;
  int           m_ptr = 0;
  logic [3:0]   m_op;
  logic [AL*IW-1:0]   m_a, m_b;
  logic [AL*2*IW-1:0] m_res;
  logic [AL-1:0]      m_gt, m_eq, m_lt;

  always @(negedge clk) begin
    logic [N-1:0] e_rr, e_rv;
    int p;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_alu_enable", alu_enable, 0);
      chk("rst_alu_bus", {alu_opcode, alu_a, alu_b}, 0);
      chk("rst_rsp_bus", {rsp_result}, 0);
      m_busy = 0; m_ptr = 0; m_t = 0;
    end else begin
      e_rr = '0; e_rv = '0; p = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++)
          if (p < 0 && req_valid[(m_ptr + k) % N]) p = (m_ptr + k) % N;
        if (p >= 0) e_rr[p] = 1'b1;
      end
      if (m_busy && m_t == L + 2) e_rv[m_g] = 1'b1;
      chk("m_req_ready", req_ready, e_rr);
      chk("m_rsp_valid", rsp_valid, e_rv);
      chk("m_alu_enable", alu_enable, m_busy && m_t >= 1 && m_t <= L + 1);
      if (m_busy && m_t >= 1 && m_t <= L + 1) chk("m_alu_bus", {alu_opcode, alu_a, alu_b}, {m_op, m_a, m_b});
      if (e_rv != 0) begin
        chk("m_rsp_result", rsp_result, m_res);
        chk("m_rsp_flags", {rsp_gt, rsp_eq, rsp_lt}, {m_gt, m_eq, m_lt});
      end
      if (p >= 0) begin
        m_busy = 1; m_g = p; m_t = 1;
        m_op = req_opcode[p*4 +: 4];
        m_a  = req_a[p*AL*IW +: AL*IW];
        m_b  = req_b[p*AL*IW +: AL*IW];
        for (int i = 0; i < AL; i++) begin
          m_res[i*2*IW +: 2*IW] = 16'(m_a[i*IW +: IW]) * 16'(m_b[i*IW +: IW]);
          m_gt[i] = m_a[i*IW +: IW] >  m_b[i*IW +: IW];
          m_eq[i] = m_a[i*IW +: IW] == m_b[i*IW +: IW];
          m_lt[i] = m_a[i*IW +: IW] <  m_b[i*IW +: IW];
        end
      end else if (m_busy) begin
        if (m_t < L + 2) m_t++;
        else if (rsp_ready[m_g]) begin
          m_busy = 0;
          m_ptr = (m_g + 1) % N;
        end
      end
    end
  end

  task automatic set_ops(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] step);
    req_opcode[r*4 +: 4] = op;
    for (int i = 0; i < AL; i++) begin
      req_a[(r*AL+i)*IW +: IW] = a + step * 8'(i);
      req_b[(r*AL+i)*IW +: IW] = b - step * 8'(i);
    end
  endtask

  // Returns the granted one-hot vector and its cycle, then steps to just after the accepting edge.
  task automatic wait_grant(output logic [N-1:0] rr, output int c);
    rr = '0; c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        rr = req_ready; c = cyc;
        @(posedge clk); #1;
        return;
      end
    end
    chk("grant_timeout", 0, 1);
  endtask

  task automatic wait_rsp(output logic [N-1:0] rv, output int c);
    rv = '0; c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid != 0) begin
        rv = rsp_valid; c = cyc;
        return;
      end
    end
    chk("rsp_timeout", 0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  int gc[5];
  int go[5];

  initial begin
    logic [N-1:0] rr, rv;
    int c0, c1;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Single operation from requester 0: all lanes 3*5.
    rsp_ready = 4'hF;
    set_ops(0, 4'h3, 8'd3, 8'd5, 8'd0);
    req_valid = 4'b0001;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    chk("t1_grant", rr, 4'b0001);
    wait_rsp(rv, c1);
    chk("t1_rsp_valid", rv, 4'b0001);
    chk("t1_latency", c1 - c0, 3);
    chk("t1_result", rsp_result, {4{16'd15}});
    chk("t1_lt", rsp_lt, 4'hF);
    chk("t1_gt_eq", {rsp_gt, rsp_eq}, 8'h00);
`ifdef ALU_ARB_BUSY_CNT_EN
    @(negedge clk);
    chk("t1_busy_cycles", busy_cycles, 32'd3);
`endif
    idle_cycles(3);

    // All four requesting continuously from a fresh pointer.
    pulse_rst();
    for (int r = 0; r < N; r++) set_ops(r, 4'(r + 1), 8'(10 + r), 8'(7 + 2*r), 8'd1);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(rr, gc[k]);
      go[k] = -1;
      for (int b = 0; b < N; b++) if (rr[b]) go[k] = b;
    end
    req_valid = 4'b0000;
    chk("t2_order", {go[0][3:0], go[1][3:0], go[2][3:0], go[3][3:0], go[4][3:0]}, 20'h01230);
    for (int k = 1; k < 5; k++) chk("t2_spacing", gc[k] - gc[k-1], L + 3);
    idle_cycles(6);

    // Pointer at 3 after serving requester 2; lone requester 1 wins via wrap.
    pulse_rst();
    req_valid = 4'b0100;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    chk("t3_grant2", rr, 4'b0100);
    idle_cycles(6);
    req_valid = 4'b0010;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    chk("t3_grant1", rr, 4'b0010);
    wait_rsp(rv, c1);
    chk("t3_rsp_valid", rv, 4'b0010);
    idle_cycles(4);

    // Response back-pressure for 10 cycles while requester 1 waits.
    rsp_ready = 4'b0000;
    set_ops(0, 4'h3, 8'd3, 8'd5, 8'd0);
    req_valid = 4'b0001;
    wait_grant(rr, c0);
    req_valid = 4'b0010;
    chk("t4_grant0", rr, 4'b0001);
    wait_rsp(rv, c1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_hold_valid", rsp_valid, 4'b0001);
      chk("t4_hold_result", rsp_result, {4{16'd15}});
      chk("t4_no_ready", req_ready, 4'b0000);
    end
    @(posedge clk); #1 rsp_ready = 4'hF;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    chk("t4_grant1", rr, 4'b0010);
    idle_cycles(6);

    // Reset in the middle of EXEC discards the operation.
    req_valid = 4'b0001;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("t5_abort_enable", alu_enable, 1'b0);
    chk("t5_abort_valid", rsp_valid, 4'b0000);
    chk("t5_abort_alu_a", alu_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", rsp_valid, 4'b0000);
    end
    @(posedge clk); #1 req_valid = 4'b0100;
    wait_grant(rr, c0);
    req_valid = 4'b0000;
    chk("t5_grant2", rr, 4'b0100);
    idle_cycles(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
